fwd_ctrl: RTL and testbench



---
 rtl/fwd_ctrl.sv | 150 +++++++++++++++
 tb/tb_fwd_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_ctrl
//  Description : Forwarding and load-use hazard controller for a 5-stage
//                MIPS pipeline. Tracks destination registers of the EX, MEM
//                and WB instructions, drives the EX operand bypass selects,
//                raises a one-cycle load-use stall, and counts stall cycles
//                with saturation.
//  Ports       : clk          - pipeline clock, rising edge
//                rst_n        - asynchronous active-low reset
//                id_valid     - ID holds a real instruction
//                id_rs/id_rt  - ID source registers A/B
//                id_dst       - ID destination register
//                id_reg_write - ID instruction writes the register file
//                id_mem_read  - ID instruction is a load
//                flush        - squash the ID->EX transfer this cycle
//                sel_a/sel_b  - bypass selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//                stall        - hold PC and IF/ID this cycle
//                stall_cnt    - saturating count of stall cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_MEM = 2'b10;
    localparam logic [1:0] c_SEL_WB  = 2'b01;

    // EX slot
    logic             r_ex_valid;
    logic [4:0]       r_ex_rs;
    logic [4:0]       r_ex_rt;
    logic [4:0]       r_ex_dst;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    // MEM slot
    logic             r_mem_valid;
    logic [4:0]       r_mem_dst;
    logic             r_mem_reg_write;
    // WB slot
    logic             r_wb_valid;
    logic [4:0]       r_wb_dst;
    logic             r_wb_reg_write;

    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_hazard;
    logic             w_stall;
    logic             w_mem_prod;
    logic             w_wb_prod;

    // A slot can only act as a forwarding source if it really writes a
    // non-zero register; $0 is hardwired and never bypassed.
    assign w_mem_prod = r_mem_valid & r_mem_reg_write & (r_mem_dst != 5'd0);
    assign w_wb_prod  = r_wb_valid  & r_wb_reg_write  & (r_wb_dst  != 5'd0);

    assign w_hazard = r_ex_valid & r_ex_mem_read & r_ex_reg_write
                    & (r_ex_dst != 5'd0) & id_valid
                    & ((r_ex_dst == id_rs) | (r_ex_dst == id_rt));

    // A taken branch squashes the dependent instruction anyway, so a flush
    // makes the stall unnecessary.
    assign w_stall = w_hazard & ~flush;

    // EX/MEM is checked first: the youngest producer holds the newest value.
    always_comb begin
        sel_a = c_SEL_RF;
        if (w_mem_prod && (r_mem_dst == r_ex_rs)) begin
            sel_a = c_SEL_MEM;
        end else if (w_wb_prod && (r_wb_dst == r_ex_rs)) begin
            sel_a = c_SEL_WB;
        end
    end

    always_comb begin
        sel_b = c_SEL_RF;
        if (w_mem_prod && (r_mem_dst == r_ex_rt)) begin
            sel_b = c_SEL_MEM;
        end else if (w_wb_prod && (r_wb_dst == r_ex_rt)) begin
            sel_b = c_SEL_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid      <= 1'b0;
            r_ex_rs         <= 5'd0;
            r_ex_rt         <= 5'd0;
            r_ex_dst        <= 5'd0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_dst       <= 5'd0;
            r_mem_reg_write <= 1'b0;
            r_wb_valid      <= 1'b0;
            r_wb_dst        <= 5'd0;
            r_wb_reg_write  <= 1'b0;
            r_stall_cnt     <= '0;
        end else begin
            r_wb_valid      <= r_mem_valid;
            r_wb_dst        <= r_mem_dst;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_valid     <= r_ex_valid;
            r_mem_dst       <= r_ex_dst;
            r_mem_reg_write <= r_ex_reg_write;

            // Stall or flush inject an all-zero bubble; a zero rs/rt also
            // keeps the bubble from selecting any bypass path.
            if (w_stall || flush) begin
                r_ex_valid     <= 1'b0;
                r_ex_rs        <= 5'd0;
                r_ex_rt        <= 5'd0;
                r_ex_dst       <= 5'd0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end else begin
                r_ex_valid     <= id_valid;
                r_ex_rs        <= id_rs;
                r_ex_rt        <= id_rt;
                r_ex_dst       <= id_dst;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
            end

            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign stall     = w_stall;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_ctrl
//  Description : Self-checking bench for fwd_ctrl. A behavioural model of the
//                in-flight instructions predicts selects, stall and counter
//                every cycle; directed sequences pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    fwd_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .sel_a        (sel_a),
        .sel_b        (sel_b),
        .stall        (stall),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
        logic       rw;
        logic       mr;
    } ins_t;

    ins_t m_pipe [3];
    int   m_cnt;

    function automatic logic m_stall();
        ins_t e = m_pipe[0];
        logic reads;
        reads = id_valid && ((e.dst == id_rs) || (e.dst == id_rt));
        return e.v && e.mr && e.rw && (e.dst != 5'd0) && reads && !flush;
    endfunction

    // Nearest older instruction that writes the register supplies it.
    function automatic logic [1:0] m_sel(input logic [4:0] r);
        if (r == 5'd0) return 2'b00;
        for (int k = 1; k <= 2; k++) begin
            if (m_pipe[k].v && m_pipe[k].rw && m_pipe[k].dst == r)
                return (k == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) m_pipe[k] = '0;
            m_cnt = 0;
        end else begin
            logic st;
            st = m_stall();
            if (st && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            if (st || flush) m_pipe[0] = '0;
            else m_pipe[0] = '{id_valid, id_rs, id_rt, id_dst, id_reg_write, id_mem_read};
        end
    end

    // Single compare process: inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("model_sel_a", 32'(sel_a), 32'(m_sel(m_pipe[0].rs)));
            chk("model_sel_b", 32'(sel_b), 32'(m_sel(m_pipe[0].rt)));
            chk("model_stall", 32'(stall), 32'(m_stall()));
            chk("model_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic rw, input logic mr,
                         input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string nm, input logic [1:0] ea, input logic [1:0] eb,
                              input logic es, input int ec);
        chk({nm, "_sel_a"}, 32'(sel_a), 32'(ea));
        chk({nm, "_sel_b"}, 32'(sel_b), 32'(eb));
        chk({nm, "_stall"}, 32'(stall), 32'(es));
        chk({nm, "_cnt"}, 32'(stall_cnt), 32'(ec));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        nop();
        tick(); tick();
        check_outs("reset", 2'b00, 2'b00, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        #1;
        do_reset();

        // add $3,$1,$2 ; sub $4,$3,$5 back to back
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd3, 5'd5, 5'd4, 1, 0, 0); tick();
        @(negedge clk); check_outs("fwd_mem", 2'b10, 2'b00, 1'b0, 0);
        nop(); tick(); tick(); tick();

        // one-instruction gap
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0); tick();
        nop(); tick();
        drive(1, 5'd3, 5'd5, 5'd4, 1, 0, 0); tick();
        @(negedge clk); check_outs("fwd_wb", 2'b01, 2'b00, 1'b0, 0);
        nop(); tick(); tick(); tick();

        // two writers of $3: youngest wins
        drive(1, 5'd1, 5'd2, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd6, 5'd7, 5'd3, 1, 0, 0); tick();
        drive(1, 5'd3, 5'd3, 5'd4, 1, 0, 0); tick();
        @(negedge clk); check_outs("fwd_prio", 2'b10, 2'b10, 1'b0, 0);
        nop(); tick(); tick(); tick();

        // $0 is never forwarded
        drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 0); tick();
        drive(1, 5'd0, 5'd0, 5'd5, 1, 0, 0); tick();
        @(negedge clk); check_outs("zero_reg", 2'b00, 2'b00, 1'b0, 0);
        nop(); tick();
        @(negedge clk); check_outs("zero_reg2", 2'b00, 2'b00, 1'b0, 0);
        tick(); tick();

        // lw $2,0($1) ; add $4,$2,$2
        drive(1, 5'd1, 5'd0, 5'd2, 1, 1, 0); tick();
        drive(1, 5'd2, 5'd2, 5'd4, 1, 0, 0);
        @(negedge clk); check_outs("lu_stall", 2'b00, 2'b00, 1'b1, 0);
        tick();
        @(negedge clk); check_outs("lu_bubble", 2'b00, 2'b00, 1'b0, 1);
        tick();
        nop();
        @(negedge clk); check_outs("lu_fwd", 2'b01, 2'b01, 1'b0, 1);
        tick(); tick(); tick();

        // load-use collides with flush: flush wins
        drive(1, 5'd1, 5'd0, 5'd2, 1, 1, 0); tick();
        drive(1, 5'd2, 5'd9, 5'd4, 1, 0, 1);
        @(negedge clk); check_outs("flush_col", 2'b00, 2'b00, 1'b0, 1);
        tick();
        nop();
        @(negedge clk); check_outs("flush_next", 2'b00, 2'b00, 1'b0, 1);
        tick(); tick(); tick();

        // asynchronous reset in the middle of a stall cycle
        drive(1, 5'd1, 5'd0, 5'd2, 1, 1, 0); tick();
        drive(1, 5'd2, 5'd2, 5'd4, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 2'b00, 2'b00, 1'b0, 0);
        #2 rst_n = 1'b1;
        nop(); tick(); tick();

        // counter saturation: 20 load-use pairs
        for (int i = 0; i < 20; i++) begin
            drive(1, 5'd1, 5'd0, 5'd2, 1, 1, 0); tick();
            drive(1, 5'd2, 5'd2, 5'd4, 1, 0, 0); tick(); tick();
            if (i == 9)  chk("sat_cnt10", 32'(stall_cnt), 32'd10);
            if (i == 14) chk("sat_cnt15", 32'(stall_cnt), 32'd15);
        end
        nop(); tick();
        chk("sat_hold", 32'(stall_cnt), 32'd15);

        // randomized traffic, with a mid-cycle reset partway through
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                #3 rst_n = 1'b0;
                #1 chk("rand_rst_cnt", 32'(stall_cnt), 32'd0);
                #1 rst_n = 1'b1;
            end
            drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 9) < 1) ? 1'b1 : 1'b0);
            tick();
        end
        nop(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
